// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: hobby-servo PWM generator.
// Samples a 10-bit position once per frame. A multicycle restoring divider maps
// it to a target pulse width. The pulse width in effect moves toward that target
// by at most SLEW_US per frame.
// Ports:
//   CLK          system clock
//   SW1_N        asynchronous active-low reset
//   EN           output enable (PWM_OUT forced low when 0)
//   i_pos        commanded position, sampled at each frame boundary
//   PWM_OUT      registered servo pulse
//   FRAME_START  one-CLK pulse after each frame boundary
//   cur_width_us pulse width (us) in effect for the current frame
//   busy         high while the divider is computing
module servo_pwm_gen #(
  parameter int unsigned CLK_FREQ_HZ  = 12000000,
  parameter int unsigned FRAME_US     = 20000,
  parameter int unsigned PULSE_MIN_US = 1000,
  parameter int unsigned PULSE_MAX_US = 2000,
  parameter logic [9:0]  MIN_POS      = 10'd228,
  parameter logic [9:0]  MAX_POS      = 10'd830,
  parameter int unsigned SLEW_US      = 20
) (
  input  logic        CLK,
  input  logic        SW1_N,
  input  logic        EN,
  input  logic [9:0]  i_pos,
  output logic        PWM_OUT,
  output logic        FRAME_START,
  output logic [11:0] cur_width_us,
  output logic        busy
);

  localparam int unsigned TICK_DIV = CLK_FREQ_HZ / 1000000;
  localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned UW       = $clog2(FRAME_US);
  localparam logic [11:0] MID      = 12'((PULSE_MIN_US + PULSE_MAX_US) / 2);
  localparam logic [9:0]  DIVISOR  = MAX_POS - MIN_POS;
  localparam logic [9:0]  RANGE    = 10'(PULSE_MAX_US - PULSE_MIN_US);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_DONE} state_t;

  state_t          r_state;
  logic [PW-1:0]   r_presc;
  logic [UW-1:0]   r_us_cnt;
  logic [11:0]     r_target_us;
  logic [9:0]      r_pos_q;
  logic [19:0]     r_quo;
  logic [9:0]      r_rem;
  logic [4:0]      r_bit;

  logic            w_tick;
  logic            w_frame_end;
  logic [9:0]      w_pos_c;
  logic [9:0]      w_off;
  logic [19:0]     w_num;
  logic [10:0]     w_rem_sh;
  logic            w_ge;
  logic [9:0]      w_rem_nx;
  logic [12:0]     w_up;
  logic [11:0]     w_slew_next;

  assign w_tick      = (r_presc == PW'(TICK_DIV - 1));
  assign w_frame_end = w_tick && (r_us_cnt == UW'(FRAME_US - 1));

  // Clamp and numerator, consumed in LOAD.
  always_comb begin
    w_pos_c = r_pos_q;
    if (r_pos_q < MIN_POS)      w_pos_c = MIN_POS;
    else if (r_pos_q > MAX_POS) w_pos_c = MAX_POS;
    w_off = w_pos_c - MIN_POS;
    w_num = 20'(w_off) * 20'(RANGE);
  end

  // One restoring-division step. The numerator bits shift out of r_quo as the
  // quotient bits shift in.
  always_comb begin
    w_rem_sh = {r_rem, r_quo[19]};
    w_ge     = (w_rem_sh >= {1'b0, DIVISOR});
    w_rem_nx = w_ge ? 10'(w_rem_sh - {1'b0, DIVISOR}) : w_rem_sh[9:0];
  end

  // Slew limit. The downward branch is guarded so cur - SLEW never wraps.
  always_comb begin
    w_up        = 13'(cur_width_us) + 13'(SLEW_US);
    w_slew_next = r_target_us;
    if (SLEW_US != 0) begin
      if ({1'b0, r_target_us} > w_up)
        w_slew_next = w_up[11:0];
      else if ((cur_width_us > 12'(SLEW_US)) &&
               (r_target_us < (cur_width_us - 12'(SLEW_US))))
        w_slew_next = cur_width_us - 12'(SLEW_US);
    end
  end

  // Timebase and PWM output.
  always_ff @(posedge CLK or negedge SW1_N) begin
    if (!SW1_N) begin
      r_presc      <= '0;
      r_us_cnt     <= '0;
      PWM_OUT      <= 1'b0;
      FRAME_START  <= 1'b0;
      cur_width_us <= MID;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick)
        r_us_cnt <= w_frame_end ? '0 : r_us_cnt + UW'(1);
      FRAME_START <= w_frame_end;
      if (w_frame_end)
        cur_width_us <= w_slew_next;
      PWM_OUT <= EN && (32'(r_us_cnt) < 32'(cur_width_us));
    end
  end

  // Divider FSM: LOAD (1) + DIV (20) with busy high, then DONE.
  always_ff @(posedge CLK or negedge SW1_N) begin
    if (!SW1_N) begin
      r_state     <= S_IDLE;
      busy        <= 1'b0;
      r_pos_q     <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_bit       <= '0;
      r_target_us <= MID;
    end else begin
      if (w_frame_end)
        r_pos_q <= i_pos;
      case (r_state)
        S_IDLE: begin
          if (w_frame_end) begin
            busy    <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_quo   <= w_num;
          r_rem   <= '0;
          r_bit   <= '0;
          r_state <= S_DIV;
        end
        S_DIV: begin
          r_rem <= w_rem_nx;
          r_quo <= {r_quo[18:0], w_ge};
          r_bit <= r_bit + 5'd1;
          if (r_bit == 5'd19) begin
            busy    <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_target_us <= 12'(PULSE_MIN_US) + r_quo[11:0];
          // A coincident boundary restarts at once; its slew used the old target.
          if (w_frame_end) begin
            busy    <= 1'b1;
            r_state <= S_LOAD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
